// File: rtl/ws2812_rx_apb.sv
// ws2812_rx_apb: APB3 receiver for a pulse-width-encoded LED data stream.
// It measures the width of each high pulse on DIN and decodes it as a 0 or a 1.
// Decoded bits are packed into NUM_WORDS 24-bit words for software to read back.
// Optional feature macro: WS2812_RX_IRQ_EN adds the IRQ output and the CONTROL.irq_en bit.
module ws2812_rx_apb #(
  parameter int HI_THRESH   = 60,
  parameter int MIN_HIGH    = 8,
  parameter int IDLE_CYCLES = 500,
  parameter int NUM_WORDS   = 8
) (
  input  logic        PCLK,
  input  logic        PRESERN,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  input  logic        DIN
`ifdef WS2812_RX_IRQ_EN
  ,
  output logic        IRQ
`endif
);

  localparam int        CAP    = NUM_WORDS * 24;
  localparam int        WIDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [15:0] MIN_C  = 16'(MIN_HIGH);
  localparam logic [15:0] HI_C   = 16'(HI_THRESH);
  localparam logic [15:0] IDLE_C = 16'(IDLE_CYCLES);
  localparam logic [7:0]  CAP_C  = 8'(CAP);

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_t;

  state_t              state_q, state_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [7:0]          bc_q, bc_d;
  logic [WIDX_W-1:0]   widx_q, widx_d;
  logic [4:0]          bidx_q, bidx_d;
  logic                fd_q, fd_d, ov_q, ov_d, gl_q, gl_d;
  logic                din_s1_q, din_s2_q, din_prev_q;
  logic                enable_q, irq_en;
  logic                bit_we, bit_val;
  logic [23:0]         words_q [NUM_WORDS];
  logic                wr_en, ctrl_wr, clr, rise, fall;
  logic                unused_bits;

  // The width counter saturates rather than wrapping, so a stuck-high line still reads as a 1.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign PREADY  = 1'b1;
  assign PSLVERR = 1'b0;
  assign wr_en   = PSEL & PENABLE & PWRITE;
  assign ctrl_wr = wr_en & (PADDR[5:2] == 4'h9);
  // clear acts on the commit edge itself and lasts exactly that one cycle
  assign clr     = ctrl_wr & PWDATA[1];
  assign rise    = din_s2_q & ~din_prev_q;
  assign fall    = ~din_s2_q & din_prev_q;
  assign unused_bits = ^{PADDR[31:6], PADDR[1:0], PWDATA[31:2]};

  // Two-flop synchronizer plus a registered copy of the synchronized line for edge detection
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      din_s1_q   <= 1'b0;
      din_s2_q   <= 1'b0;
      din_prev_q <= 1'b0;
    end else begin
      din_s1_q   <= DIN;
      din_s2_q   <= din_s1_q;
      din_prev_q <= din_s2_q;
    end
  end

  // CONTROL register: enable (and irq_en when the IRQ feature is built)
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) enable_q <= 1'b0;
    else if (ctrl_wr) enable_q <= PWDATA[0];
  end

`ifdef WS2812_RX_IRQ_EN
  logic irq_en_q, irq_q;
  assign irq_en = irq_en_q;
  assign IRQ    = irq_q;

  // irq_en bit and the IRQ flop; IRQ follows the next-state flags so it rises with frame_done
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en_q <= PWDATA[2];
      irq_q <= fd_d & (ctrl_wr ? PWDATA[2] : irq_en_q);
    end
  end
`else
  assign irq_en = 1'b0;
`endif

  // Receiver next state: pulse measurement, classification, packing pointers and flags
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bc_d    = bc_q;
    widx_d  = widx_q;
    bidx_d  = bidx_q;
    fd_d    = fd_q;
    ov_d    = ov_q;
    gl_d    = gl_q;
    bit_we  = 1'b0;
    bit_val = 1'b0;
    if (clr) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      bc_d    = '0;
      widx_d  = '0;
      bidx_d  = '0;
      fd_d    = 1'b0;
      ov_d    = 1'b0;
      gl_d    = 1'b0;
    end else if (!enable_q) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_d = '0;
          if (rise && !fd_q) begin
            state_d = S_HIGH;
            cnt_d   = 16'd1;
          end
        end
        S_HIGH: begin
          if (fall) begin
            state_d = S_LOW;
            cnt_d   = 16'd1;
            if (cnt_q < MIN_C) begin
              gl_d = 1'b1;
            end else if (bc_q == CAP_C) begin
              ov_d = 1'b1;
            end else begin
              bit_we  = 1'b1;
              bit_val = (cnt_q >= HI_C);
              bc_d    = bc_q + 8'd1;
              if (bidx_q == 5'd23) begin
                bidx_d = '0;
                widx_d = widx_q + 1'b1;
              end else begin
                bidx_d = bidx_q + 5'd1;
              end
            end
          end else begin
            cnt_d = sat_inc(cnt_q);
          end
        end
        S_LOW: begin
          if (rise) begin
            state_d = S_HIGH;
            cnt_d   = 16'd1;
          end else if (cnt_q >= IDLE_C) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            if (bc_q != 8'd0) fd_d = 1'b1;
          end else begin
            cnt_d = sat_inc(cnt_q);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Receiver state registers
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bc_q    <= '0;
      widx_q  <= '0;
      bidx_q  <= '0;
      fd_q    <= 1'b0;
      ov_q    <= 1'b0;
      gl_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bc_q    <= bc_d;
      widx_q  <= widx_d;
      bidx_q  <= bidx_d;
      fd_q    <= fd_d;
      ov_q    <= ov_d;
      gl_q    <= gl_d;
    end
  end

  // Word buffer: one decoded bit written per accepted pulse; survives clear
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      for (int i = 0; i < NUM_WORDS; i++) words_q[i] <= '0;
    end else if (bit_we) begin
      words_q[widx_q][bidx_q] <= bit_val;
    end
  end

  // APB read mux, combinational from PADDR while a read is selected
  always_comb begin
    PRDATA = '0;
    if (PSEL && !PWRITE) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        if (i < 8 && PADDR[5:2] == 4'(i)) PRDATA = {8'h00, words_q[i]};
      end
      if (PADDR[5:2] == 4'h8) PRDATA = {16'h0000, bc_q, 5'b00000, gl_q, ov_q, fd_q};
      if (PADDR[5:2] == 4'h9) PRDATA = {29'h0, irq_en, 1'b0, enable_q};
    end
  end

endmodule

// File: tb/tb_ws2812_rx_apb.sv
// Directed bench for ws2812_rx_apb with a behavioural model and an expected-value queue.
module tb_ws2812_rx_apb;

  logic        PCLK = 1'b0, PRESERN = 1'b0;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0, DIN = 1'b0;
  logic [31:0] PADDR = '0, PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
`ifdef WS2812_RX_IRQ_EN
  logic        IRQ;
`endif

  int          tests = 0, fails = 0;
  logic [31:0] exp_q[$];
  logic [23:0] m_words[8];
  int          m_bc = 0;
  bit          m_fd = 0, m_ov = 0, m_gl = 0, m_en = 0, m_irqen = 0;

  ws2812_rx_apb dut (
    .PCLK(PCLK), .PRESERN(PRESERN), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .DIN(DIN)
`ifdef WS2812_RX_IRQ_EN
    , .IRQ(IRQ)
`endif
  );

  always #5 PCLK = ~PCLK;

  task automatic tick(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got);
    logic [31:0] expv;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL %s: got %h but no expected value queued", tag, got);
    end else begin
      expv = exp_q.pop_front();
      assert (got === expv) else begin
        fails++;
        $error("FAIL %s: got %h expected %h", tag, got, expv);
      end
    end
  endtask

  task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = addr;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #2 data = PRDATA;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] expv);
    logic [31:0] d;
    exp_q.push_back(expv);
    apb_read(addr, d);
    check(tag, d);
  endtask

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = addr; PWDATA = data;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    if (addr[5:2] == 4'h9) begin
      m_en = data[0];
`ifdef WS2812_RX_IRQ_EN
      m_irqen = data[2];
`endif
      if (data[1]) begin
        m_bc = 0; m_fd = 0; m_ov = 0; m_gl = 0;
      end
    end
  endtask

  function automatic logic [31:0] status_exp();
    return {16'h0000, 8'(m_bc), 5'b00000, m_gl, m_ov, m_fd};
  endfunction

  function automatic logic [31:0] ctrl_exp();
    return {29'h0, m_irqen, 1'b0, m_en};
  endfunction

  task automatic pulse(input int hi, input int lo);
    DIN = 1'b1; tick(hi);
    DIN = 1'b0; tick(lo);
  endtask

  task automatic send_bit(input bit b);
    pulse(b ? 81 : 41, b ? 44 : 84);
    if (m_en && !m_fd) begin
      if (m_bc < 192) begin
        m_words[m_bc / 24][m_bc % 24] = b;
        m_bc++;
      end else begin
        m_ov = 1;
      end
    end
  endtask

  task automatic send_word(input logic [23:0] v);
    for (int i = 0; i < 24; i++) send_bit(v[i]);
  endtask

  task automatic idle(input int n);
    DIN = 1'b0; tick(n);
    if (m_en && !m_fd && m_bc > 0 && n >= 520) m_fd = 1;
  endtask

  task automatic check_words(input string tag);
    for (int i = 0; i < 8; i++)
      rd_chk($sformatf("%s_word%0d", tag, i), 32'(i * 4), {8'h00, m_words[i]});
  endtask

  task automatic check_all(input string tag);
    check_words(tag);
    rd_chk({tag, "_status"}, 32'h20, status_exp());
    rd_chk({tag, "_control"}, 32'h24, ctrl_exp());
  endtask

  initial begin
    for (int i = 0; i < 8; i++) m_words[i] = '0;

    // reset state
    tick(3);
    PRESERN = 1'b1;
    tick(2);
    exp_q.push_back(32'h1); check("pready", {31'h0, PREADY});
    exp_q.push_back(32'h0); check("pslverr", {31'h0, PSLVERR});
    exp_q.push_back(32'h0); check("prdata_idle", PRDATA);
`ifdef WS2812_RX_IRQ_EN
    exp_q.push_back(32'h0); check("irq_reset", {31'h0, IRQ});
`endif
    check_all("reset");
    rd_chk("unmapped", 32'h28, 32'h0);

    // first frame 0xA5C3F0
    apb_write(32'h24, 32'h1);
    rd_chk("ctrl_en", 32'h24, ctrl_exp());
    send_word(24'hA5C3F0);
    idle(600);
    rd_chk("f1_word0", 32'h00, 32'h00A5C3F0);
    rd_chk("f1_status", 32'h20, 32'h00001801);
    check_all("f1");

    // second frame while frame_done is held: ignored
    send_word(24'h123456);
    idle(600);
    check_all("hold");

    // clear + enable, frame 0x000001
    apb_write(32'h24, 32'h3);
    rd_chk("clr_status", 32'h20, 32'h0);
    rd_chk("clr_ctrl", 32'h24, 32'h1);
    send_word(24'h000001);
    idle(600);
    rd_chk("f2_word0", 32'h00, 32'h00000001);
    rd_chk("f2_status", 32'h20, 32'h00001801);

    // 200 ones: buffer full, overflow
    apb_write(32'h24, 32'h3);
    for (int i = 0; i < 200; i++) send_bit(1'b1);
    idle(600);
    rd_chk("ovf_status", 32'h20, 32'h0000C003);
    check_all("ovf");

    // glitch between valid bits
    apb_write(32'h24, 32'h3);
    send_bit(1'b1);
    pulse(4, 80);
    if (m_en && !m_fd) m_gl = 1;
    send_bit(1'b0);
    send_bit(1'b1);
    idle(600);
    rd_chk("glitch_status", 32'h20, 32'h00000305);
    rd_chk("glitch_word0", 32'h00, 32'h00FFFFFD);

`ifdef WS2812_RX_IRQ_EN
    apb_write(32'h24, 32'h7);
    exp_q.push_back(32'h0); check("irq_low", {31'h0, IRQ});
    send_word(24'h5A5A5A);
    idle(600);
    exp_q.push_back(32'h1); check("irq_high", {31'h0, IRQ});
    rd_chk("irq_ctrl", 32'h24, 32'h5);
    apb_write(32'h24, 32'h7);
    exp_q.push_back(32'h0); check("irq_clear", {31'h0, IRQ});
`else
    apb_write(32'h24, 32'h5);
    rd_chk("ctrl_noirq", 32'h24, 32'h1);
`endif

    // asynchronous reset during bit 10
    apb_write(32'h24, 32'h3);
    for (int i = 0; i < 9; i++) send_bit(i[0]);
    DIN = 1'b1; tick(30);
    PRESERN = 1'b0; tick(2);
    PRESERN = 1'b1;
    for (int i = 0; i < 8; i++) m_words[i] = '0;
    m_bc = 0; m_fd = 0; m_ov = 0; m_gl = 0; m_en = 0; m_irqen = 0;
    tick(51);
    DIN = 1'b0; tick(44);
    check_all("midreset");
    send_word(24'hFFFFFF);
    idle(600);
    check_all("disabled");
    apb_write(32'h24, 32'h1);
    send_bit(1'b1);
    idle(600);
    rd_chk("reen_status", 32'h20, 32'h00000101);
    rd_chk("reen_word0", 32'h00, 32'h00000001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ws2812_rx_apb.md
# ws2812_rx_apb

APB3 peripheral that receives and decodes a single-wire, pulse-width-encoded LED data stream: the receiving end of the team's LED driver. It measures each high pulse on `DIN` in `PCLK` cycles, classifies it as a 0 or a 1, and packs the bits into eight 24-bit colour words that software reads back over APB. It serves as a loopback and verification companion to the LED driver, and as the input stage for chained LED boards.

## Interface

Parameters:
- `HI_THRESH`, 60: high pulse of at least this many cycles decodes as 1; shorter decodes as 0.
- `MIN_HIGH`, 8: high pulses shorter than this are glitches.
- `IDLE_CYCLES`, 500: low time (cycles) that ends a frame.
- `NUM_WORDS`, 8: number of 24-bit words in the buffer (frame capacity is `NUM_WORDS*24` bits).

Ports:
- `PCLK` in 1: the single clock.
- `PRESERN` in 1: reset, asynchronous, active-low.
- `PSEL` in 1: APB peripheral select.
- `PENABLE` in 1: APB access phase.
- `PWRITE` in 1: 1 = write, 0 = read.
- `PADDR` in 32: byte address; only `[5:2]` is decoded.
- `PWDATA` in 32: write data.
- `PRDATA` out 32: read data.
- `PREADY` out 1: tied to 1.
- `PSLVERR` out 1: tied to 0.
- `DIN` in 1: asynchronous serial LED data.
- `IRQ` out 1: present only with `WS2812_RX_IRQ_EN`.

## Operation

Register map (`PADDR[5:2]`):
- 0x0–0x7 WORDn (RO): decoded bits in `[23:0]`; `[31:24]` read 0.
- 0x8 STATUS (RO):
  - `[0]` frame_done
  - `[1]` overflow
  - `[2]` glitch_err
  - `[15:8]` bit_count
- 0x9 CONTROL (RW):
  - `[0]` enable
  - `[1]` clear (write-1 pulse, reads 0)
  - `[2]` irq_en
- Other addresses: reads return 0, writes are ignored.

APB behaviour:
- A write commits on the cycle where `PSEL & PENABLE & PWRITE`.
- `PRDATA` is combinational from `PADDR` while `PSEL & ~PWRITE`; otherwise it is 0.
- Reads have no side effects.

Input path:
- `DIN` passes through a 2-flop synchronizer.
- Edges are detected on the synchronized signal against a registered copy of it.

Receiver FSM:
- Width counter `cnt`: 16 bits, saturating at 0xFFFF.
- `IDLE`: `cnt` = 0. A rising edge with enable=1 and frame_done=0 → `HIGH`, `cnt` = 1.
- `HIGH`: `cnt` increments each cycle. On the falling edge:
  - `cnt < MIN_HIGH`: set glitch_err, discard the bit.
  - `cnt >= HI_THRESH`: bit value 1.
  - otherwise: bit value 0.
  - In every case → `LOW`, `cnt` = 1.
- `LOW`: `cnt` increments.
  - Rising edge → `HIGH`, `cnt` = 1.
  - `cnt` reaches `IDLE_CYCLES` with bit_count > 0 → set frame_done, go to `IDLE`.
  - `cnt` reaches `IDLE_CYCLES` with bit_count = 0 → `IDLE` only.

Bit packing:
- Received bit i is written to WORD[i/24] bit (i%24); the first bit lands in WORD0 bit 0.
- bit_count is 8 bits and increments per accepted bit.
- At bit_count = `NUM_WORDS*24` (192), further bits set overflow and are dropped; bit_count holds at 192.

Hold after frame end:
- While frame_done=1 the FSM stays in `IDLE` and ignores `DIN` until software issues clear.
- clear zeroes bit_count, frame_done, overflow, glitch_err and `cnt`, and forces `IDLE`. WORD contents are retained.

enable=0 behaviour:
- The FSM is forced to `IDLE` and `cnt` to 0.
- Flags and words are retained.
- A pulse in progress is abandoned and no bit is recorded.

Simultaneous events:
- clear in the same cycle as a frame end or bit accept: clear wins, and nothing is recorded.

## Timing

- Reset values:
  - `PRDATA` = 0, `IRQ` = 0.
  - All WORDs = 0, STATUS = 0, CONTROL = 0 (receiver disabled).
  - FSM in `IDLE`, synchronizer flops = 0.
- Bit accept: WORD and bit_count update 3 cycles after the `DIN` falling edge (2 synchronizer cycles + 1 edge register).
- frame_done rises `IDLE_CYCLES` cycles after the last synchronized falling edge.
- Pulse widths are measured in synchronized cycles. The ±1 cycle jitter this introduces is absorbed by the thresholds.
- A CONTROL write takes effect on the following cycle. clear is a single-cycle internal pulse.
- An asynchronous reset mid-frame discards all state immediately.

## Configuration

- `WS2812_RX_IRQ_EN` defined:
  - `IRQ` port exists, registered, `IRQ = frame_done & irq_en`.
  - It stays high until clear or until irq_en is written to 0.
- `WS2812_RX_IRQ_EN` undefined:
  - No `IRQ` port.
  - CONTROL[2] reads 0 and writes to it are ignored.

## Test plan

- Enable, drive 24 bits of 0xA5C3F0, LSB first (1: 81 high / 44 low; 0: 41 high / 84 low), then hold low 600 cycles → WORD0 = 0x00A5C3F0, STATUS = 0x00001801.
- Drive 200 bits of 1 → WORD0–7 = 0x00FFFFFF, bit_count = 192, overflow = 1, frame_done = 1.
- Drive a 4-cycle high pulse between valid bits → glitch_err = 1, bit not counted; surrounding bits decode correctly.
- After frame_done, drive a second frame without clear → WORDs unchanged. Write CONTROL = 0x3, then drive 0x000001 → WORD0 = 0x000001, bit_count = 24.
- Assert `PRESERN` low during bit 10 of a frame → all registers read 0, `DIN` ignored until enable is rewritten.
- With `WS2812_RX_IRQ_EN` and irq_en = 1, complete a 24-bit frame → `IRQ` rises with frame_done; writing clear drops `IRQ` the following cycle.
